// File: rtl/decimal_counter_ctrl.sv
// decimal_counter_ctrl
// Run/pause/clear controller for a four-digit BCD event counter. A prescaler
// turns clk into count ticks at one of two rates. A four-state sequencer
// (IDLE/RUN/PAUSE/DONE) steps the prescaler and the BCD digits. All outputs
// are registered.
//
// Commands are levels, and the priority on every edge is clear > stop > start.
// When stop or clear arrives on the same edge as a prescaler limit hit, the
// command wins: the counter does not increment and no tick is produced.

module decimal_counter_ctrl #(
    parameter int unsigned FAST_DIV    = 10_000_000,
    parameter int unsigned SLOW_DIV    = 100_000_000,
    parameter bit          STOP_AT_MAX = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        a,
    output logic [15:0] bcd,
    output logic        tick,
    output logic        carry_out,
    output logic        running,
    output logic        done,
    output logic [1:0]  dbg_state
);

    // The prescaler is sized for the larger divider, so it never overflows.
    localparam int unsigned MAX_DIV = (FAST_DIV > SLOW_DIV) ? FAST_DIV : SLOW_DIV;
    localparam int          CC_W    = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

    localparam logic [CC_W-1:0] FAST_LIM = CC_W'(FAST_DIV - 1);
    localparam logic [CC_W-1:0] SLOW_LIM = CC_W'(SLOW_DIV - 1);
    localparam logic [CC_W-1:0] CC_ONE   = CC_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CC_W-1:0] r_cc;
    logic [15:0]     r_bcd;
    logic            r_tick;
    logic            r_carry;
    logic            r_running;
    logic            r_done;

    logic [CC_W-1:0] w_limit;
    logic            w_hit;
    logic [15:0]     w_bcd_inc;
    logic            w_wrap;
    logic            w_ripple;

    // Limit select: the limit is picked by a mask rather than a mux, so it
    // follows `a` on every cycle.
    always_comb begin
        w_limit = ({CC_W{a}} & FAST_LIM) | ({CC_W{~a}} & SLOW_LIM);
        w_hit   = (r_cc >= w_limit);
    end

    // BCD ripple increment: a digit at 9 rolls to 0 and passes the carry on.
    always_comb begin
        w_bcd_inc = r_bcd;
        w_ripple  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w_ripple) begin
                if (r_bcd[4*i +: 4] >= 4'd9) begin
                    w_bcd_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_bcd_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_ripple            = 1'b0;
                end
            end
        end
        w_wrap = (r_bcd == 16'h9999);
    end

    // Sequencer, prescaler and digit register, with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cc      <= '0;
            r_bcd     <= '0;
            r_tick    <= 1'b0;
            r_carry   <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_tick  <= 1'b0;
            r_carry <= 1'b0;
            if (clear) begin
                r_state   <= S_IDLE;
                r_cc      <= '0;
                r_bcd     <= '0;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_cc  <= '0;
                        r_bcd <= '0;
                        // stop has no effect here, so start alone decides.
                        if (start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (stop) begin
                            r_state   <= S_PAUSE;
                            r_running <= 1'b0;
                        end else if (w_hit) begin
                            r_cc   <= '0;
                            r_tick <= 1'b1;
                            r_bcd  <= w_bcd_inc;
                            if (STOP_AT_MAX && (w_bcd_inc == 16'h9999)) begin
                                r_state   <= S_DONE;
                                r_running <= 1'b0;
                                r_done    <= 1'b1;
                            end else begin
                                r_carry <= w_wrap;
                            end
                        end else begin
                            r_cc <= r_cc + CC_ONE;
                        end
                    end
                    S_PAUSE: begin
                        // Resume from the held prescaler count.
                        if (start) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_cc <= '0;
                    end
                    default: begin
                        r_state   <= S_IDLE;
                        r_running <= 1'b0;
                        r_done    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bcd       = r_bcd;
    assign tick      = r_tick;
    assign carry_out = r_carry;
    assign running   = r_running;
    assign done      = r_done;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_decimal_counter_ctrl.sv
// Bench for decimal_counter_ctrl. Two instances share one stimulus stream:
// one wraps at 9999 and the other stops at 9999. An integer-count reference
// model predicts every output on every cycle.

module tb_decimal_counter_ctrl;

    localparam int FAST = 4;
    localparam int SLOW = 10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        clear = 1'b0;
    logic        a = 1'b1;

    logic [15:0] bcd0, bcd1;
    logic        tick0, tick1, carry0, carry1, run0, run1, done0, done1;
    logic [1:0]  dbg0, dbg1;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the count is a plain integer 0..9999, digits derived by arithmetic.
    int m_state[2];
    int m_cc[2];
    int m_cnt[2];
    bit m_tick[2];
    bit m_carry[2];

    logic [15:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    decimal_counter_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .STOP_AT_MAX(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .a(a),
        .bcd(bcd0), .tick(tick0), .carry_out(carry0), .running(run0), .done(done0),
        .dbg_state(dbg0)
    );

    decimal_counter_ctrl #(.FAST_DIV(FAST), .SLOW_DIV(SLOW), .STOP_AT_MAX(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .a(a),
        .bcd(bcd1), .tick(tick1), .carry_out(carry1), .running(run1), .done(done1),
        .dbg_state(dbg1)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'((n / 1000) % 10);
        d2 = 4'((n / 100) % 10);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_update(input int k);
        int lim;
        lim = a ? (FAST - 1) : (SLOW - 1);
        m_tick[k]  = 1'b0;
        m_carry[k] = 1'b0;
        if (rst || clear) begin
            m_state[k] = M_IDLE;
            m_cc[k]    = 0;
            m_cnt[k]   = 0;
        end else begin
            case (m_state[k])
                M_IDLE:  if (start) m_state[k] = M_RUN;
                M_RUN: begin
                    if (stop) begin
                        m_state[k] = M_PAUSE;
                    end else if (m_cc[k] >= lim) begin
                        m_cc[k]   = 0;
                        m_tick[k] = 1'b1;
                        m_cnt[k]  = (m_cnt[k] + 1) % 10000;
                        if (m_cnt[k] == 0) m_carry[k] = 1'b1;
                        if (k == 1 && m_cnt[k] == 9999) m_state[k] = M_DONE;
                    end else begin
                        m_cc[k] = m_cc[k] + 1;
                    end
                end
                M_PAUSE: if (start) m_state[k] = M_RUN;
                default: ;
            endcase
        end
        if (k == 0 && m_tick[0]) exp_q.push_back(to_bcd(m_cnt[0]));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then sample.
    task automatic step();
        @(posedge clk);
        model_update(0);
        model_update(1);
        #1;
        check_eq("bcd0",   32'(bcd0),   32'(to_bcd(m_cnt[0])));
        check_eq("tick0",  32'(tick0),  32'(m_tick[0]));
        check_eq("carry0", 32'(carry0), 32'(m_carry[0]));
        check_eq("run0",   32'(run0),   32'(m_state[0] == M_RUN));
        check_eq("done0",  32'(done0),  32'(m_state[0] == M_DONE));
        check_eq("bcd1",   32'(bcd1),   32'(to_bcd(m_cnt[1])));
        check_eq("tick1",  32'(tick1),  32'(m_tick[1]));
        check_eq("carry1", 32'(carry1), 32'(m_carry[1]));
        check_eq("run1",   32'(run1),   32'(m_state[1] == M_RUN));
        check_eq("done1",  32'(done1),  32'(m_state[1] == M_DONE));
        if (tick0) begin
            check_eq("tick_q_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check_eq("tick_value", 32'(bcd0), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_clear();
        clear = 1'b1; step(); clear = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n_ticks;
        int r;

        for (int k = 0; k < 2; k++) begin
            m_state[k] = M_IDLE; m_cc[k] = 0; m_cnt[k] = 0; m_tick[k] = 0; m_carry[k] = 0;
        end

        // 1: reset, then stay idle
        run_cycles(3);
        rst = 1'b0;
        a   = 1'b1;
        run_cycles(20);
        check_eq("s1_bcd_idle", 32'(bcd0), 32'h0);
        check_eq("s1_run_idle", 32'(run0), 32'h0);

        // 2: fast rate, then slow rate
        do_start();
        n_ticks = 0;
        for (int i = 0; i < 40; i++) begin step(); if (tick0) n_ticks++; end
        check_eq("s2_fast_ticks", 32'(n_ticks), 32'd10);
        check_eq("s2_bcd_10", 32'(bcd0), 32'h0010);
        a = 1'b0;
        n_ticks = 0;
        for (int i = 0; i < 40; i++) begin step(); if (tick0) n_ticks++; end
        check_eq("s2_slow_ticks", 32'(n_ticks), 32'd4);
        check_eq("s2_bcd_14", 32'(bcd0), 32'h0014);

        // 3: pause at 9 and resume from the held prescaler
        a = 1'b1;
        do_clear();
        do_start();
        run_cycles(36);
        check_eq("s3_bcd_9", 32'(bcd0), 32'h0009);
        run_cycles(2);
        stop = 1'b1; step(); stop = 1'b0;
        check_eq("s3_paused", 32'(run0), 32'h0);
        run_cycles(30);
        check_eq("s3_bcd_hold", 32'(bcd0), 32'h0009);
        do_start();
        n_ticks = 0;
        for (int i = 0; i < 12 && n_ticks == 0; i++) begin step(); if (tick0) n_ticks = i + 1; end
        check_eq("s3_resume_latency", 32'(n_ticks), 32'd2);
        check_eq("s3_bcd_10", 32'(bcd0), 32'h0010);

        // 5: stop on the limit edge
        do_clear();
        do_start();
        run_cycles(3);
        stop = 1'b1; step(); stop = 1'b0;
        check_eq("s5_no_tick", 32'(tick0), 32'h0);
        check_eq("s5_bcd", 32'(bcd0), 32'h0);
        check_eq("s5_paused", 32'(run0), 32'h0);
        run_cycles(5);

        // 6: clear with start in RUN, then reset mid-run
        do_clear();
        do_start();
        run_cycles(168);
        check_eq("s6_bcd_42", 32'(bcd0), 32'h0042);
        clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
        check_eq("s6_clear_bcd", 32'(bcd0), 32'h0);
        check_eq("s6_clear_run", 32'(run0), 32'h0);
        start = 1'b1; step(); step(); start = 1'b0;
        run_cycles(10);
        rst = 1'b1; step(); rst = 1'b0;
        check_eq("s6_rst_bcd", 32'(bcd0), 32'h0);
        check_eq("s6_rst_tick", 32'(tick0), 32'h0);
        check_eq("s6_rst_run", 32'(run0), 32'h0);

        // 4: run to 9999, then wrap on one instance and stop on the other
        a = 1'b1;
        do_start();
        run_cycles(39996);
        check_eq("s4_bcd0_9999", 32'(bcd0), 32'h9999);
        check_eq("s4_bcd1_9999", 32'(bcd1), 32'h9999);
        check_eq("s4_done1", 32'(done1), 32'h1);
        check_eq("s4_run1", 32'(run1), 32'h0);
        run_cycles(4);
        check_eq("s4_wrap_bcd", 32'(bcd0), 32'h0);
        check_eq("s4_wrap_tick", 32'(tick0), 32'h1);
        check_eq("s4_wrap_carry", 32'(carry0), 32'h1);
        step();
        check_eq("s4_carry_one_cycle", 32'(carry0), 32'h0);
        do_start();
        check_eq("s4_start_ignored", 32'(done1), 32'h1);
        check_eq("s4_done_bcd", 32'(bcd1), 32'h9999);
        do_clear();
        check_eq("s4_clear_bcd1", 32'(bcd1), 32'h0);
        check_eq("s4_clear_done1", 32'(done1), 32'h0);

        // Random commands and rate changes against the model
        for (int i = 0; i < 3000; i++) begin
            r     = int'($urandom_range(0, 199));
            clear = (r < 3);
            stop  = (r >= 3 && r < 9);
            start = (r >= 9 && r < 30);
            rst   = (r == 199);
            if ($urandom_range(0, 49) == 0) a = ~a;
            step();
        end
        clear = 1'b0; stop = 1'b0; start = 1'b0; rst = 1'b0;
        run_cycles(2);

        check_eq("tick_q_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
